spi_controller: RTL

- SPI initiator (mode 0: CPOL=0, CPHA=0; MSB first; full duplex) that drives frames into the titan SPI responder port (spi_clock/spi_cs/spi_pico/spi_poci).
- Used as the on-chip bench driver, and as a loopback/self-test source for titan from user logic.
- Provides a single-word start/done handshake on the system side.
- Generates SCK from sys_clock_i with a programmable divider and frames each word with CS setup, hold and inter-frame gap.

---
 rtl/spi_controller_pkg.sv | 24 ++
 rtl/spi_phase_timer.sv | 37 +++
 rtl/spi_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_controller_pkg.sv
// Shared definitions for the SPI initiator: FSM state encoding, SPI mode
// constants and the counter-width helper used by the divider and bit counter.
package spi_controller_pkg;

    // Frame sequencing states; encoding is fixed so debug probes stay stable.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } spi_state_e;

    // Mode 0 only: SCK idles low, data is sampled on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: while enabled, strobes o_phase_end on every CLK_DIV-th cycle.
// The count restarts from zero whenever the timer is disabled, so the first
// enabled cycle is always cycle 0 of a fresh phase.
module spi_phase_timer
    import spi_controller_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_phase_end
);

    localparam int              CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last   = (r_count == LAST);
    assign o_phase_end = i_enable && w_at_last;

    // Divider count: 0..CLK_DIV-1 while enabled, parked at 0 otherwise.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would create ordering races.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            r_count <= '0;
        end else if (w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI initiator, mode 0, MSB first, full duplex. One word per start/done
// handshake; SCK, CS setup, CS hold and the inter-frame gap all share the
// CLK_DIV-cycle phase length produced by spi_phase_timer.
module spi_controller
    import spi_controller_pkg::*;
#(
    parameter int WORD_BITS = 32,
    parameter int CLK_DIV   = 4
) (
    input  logic                 sys_clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WORD_BITS-1:0] tx_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WORD_BITS-1:0] rx_data_o,
    output logic                 spi_clock_o,
    output logic                 spi_cs_o,
    output logic                 spi_pico_o,
    input  logic                 spi_poci_i
);

    localparam int               BIT_W    = cnt_width(WORD_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_BITS - 1);

    spi_state_e           r_state;
    logic [WORD_BITS-1:0] r_shift_tx;
    logic [WORD_BITS-1:0] r_shift_rx;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [WORD_BITS-1:0] r_rx_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sclk;
    logic                 r_cs_n;

    logic                 w_timer_en;
    logic                 w_phase_end;
    logic                 w_last_bit;
    logic [WORD_BITS-1:0] w_tx_shifted;
    logic [WORD_BITS-1:0] w_rx_shifted;

    // The divider only runs while a frame (including its gap) is in flight.
    assign w_timer_en = (r_state != S_IDLE);
    assign w_last_bit = (r_bit_cnt == LAST_BIT);

    // The MSB of the transmit shifter is the line itself: it is loaded on
    // accept, shifted at each HIGH->LOW transition, and cleared back to idle.
    assign w_tx_shifted = r_shift_tx << 1;

    generate
        if (WORD_BITS > 1) begin : g_rx_wide
            assign w_rx_shifted = {r_shift_rx[WORD_BITS-2:0], spi_poci_i};
        end else begin : g_rx_narrow
            assign w_rx_shifted = spi_poci_i;
        end
    endgenerate

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .i_clk       (sys_clock_i),
        .i_rst       (reset_i),
        .i_enable    (w_timer_en),
        .o_phase_end (w_phase_end)
    );

    // Frame sequencer: owns the shift registers, bit counter and all
    // registered SPI/handshake outputs. Reset takes priority over start_i.
    // NOTE: every register, including the data shifters and rx_data_o, is
    // cleared on reset because an abandoned frame must not leak stale data.
    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_bit_cnt  <= '0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= SPI_CPOL;
            r_cs_n     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_shift_tx <= tx_data_i;
                        r_shift_rx <= '0;
                        r_bit_cnt  <= '0;
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_phase_end) begin
                        r_sclk  <= ~SPI_CPOL;
                        r_state <= S_HIGH;
                    end
                end

                S_HIGH: begin
                    if (w_phase_end) begin
                        // Sample at the end of the high phase, just before SCK falls.
                        r_shift_rx <= w_rx_shifted;
                        r_sclk     <= SPI_CPOL;
                        if (w_last_bit) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_shift_tx <= w_tx_shifted;
                            r_state    <= S_LOW;
                        end
                    end
                end

                S_LOW: begin
                    if (w_phase_end) begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        r_sclk    <= ~SPI_CPOL;
                        r_state   <= S_HIGH;
                    end
                end

                S_HOLD: begin
                    if (w_phase_end) begin
                        r_cs_n    <= 1'b1;
                        r_rx_data <= r_shift_rx;
                        r_done    <= 1'b1;
                        r_state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (w_phase_end) begin
                        r_busy     <= 1'b0;
                        r_shift_tx <= '0;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign rx_data_o   = r_rx_data;
    assign spi_clock_o = r_sclk;
    assign spi_cs_o    = r_cs_n;
    assign spi_pico_o  = r_shift_tx[WORD_BITS-1];

endmodule
